// File: rtl/control_sequencer.sv
// Hardwired control unit for the ALU datapath system: fetches a 16-bit instruction
// as two bytes into IR, decodes it and sequences RF/ARF/ALU/memory transfers.
module control_sequencer #(
    parameter int          SC_WIDTH = 3,
    parameter logic [5:0]  HALT_OPC = 6'h3F
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  Flags,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [2:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted
);

    typedef enum logic [1:0] {S_CLR, S_RUN, S_HALT} seqState;

    localparam logic [SC_WIDTH-1:0] T0 = SC_WIDTH'(0);
    localparam logic [SC_WIDTH-1:0] T1 = SC_WIDTH'(1);
    localparam logic [SC_WIDTH-1:0] T2 = SC_WIDTH'(2);
    localparam logic [SC_WIDTH-1:0] T3 = SC_WIDTH'(3);

    localparam logic [5:0] OPC_BRA = 6'h00, OPC_BNE = 6'h01, OPC_BEQ = 6'h02,
                           OPC_LDI = 6'h03, OPC_ADD = 6'h04, OPC_SUB = 6'h05,
                           OPC_AND = 6'h06, OPC_ORR = 6'h07, OPC_LD  = 6'h08,
                           OPC_ST  = 6'h09;

    localparam logic [2:0] FUN_INC = 3'b001, FUN_LOAD = 3'b010, FUN_CLR = 3'b011;
    // ARF enables are active-low, {PC,AR,SP} on bits 2..0
    localparam logic [2:0] ARF_PC = 3'b011, ARF_AR = 3'b101, ARF_NONE = 3'b111;

    seqState              state, nextState;
    logic [SC_WIDTH-1:0]  stepCnt, nextStep;

    logic [5:0] opc;
    logic [1:0] rd, rs1, rs2;
    logic [3:0] rdEn;
    logic       zFlag;
    logic       unusedBits;

    assign opc   = IROut[15:10];
    assign rd    = IROut[9:8];
    assign rs1   = IROut[5:4];
    assign rs2   = IROut[3:2];
    assign zFlag = Flags[3];
    // Rd=0 selects R1 on bit 3; enables are active-low
    assign rdEn  = ~(4'b1000 >> rd);
    // Immediate bits feed the datapath muxes directly; C/N/O are not used for branching
    assign unusedBits = ^{Flags[2:0], IROut[7:6], IROut[1:0]};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= S_CLR;
            stepCnt <= T0;
        end else begin
            state   <= nextState;
            stepCnt <= nextStep;
        end
    end

    // NOTE: every output and next-state signal gets a default first so no latch is inferred.
    always_comb begin
        nextState   = state;
        nextStep    = stepCnt;
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        RF_FunSel   = 3'b000;
        RF_RegSel   = 4'b1111;
        RF_ScrSel   = 4'b1111;
        ALU_FunSel  = 5'b00000;
        ALU_WF      = 1'b0;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 3'b000;
        ARF_RegSel  = ARF_NONE;
        IR_LH       = 1'b0;
        IR_Write    = 1'b0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        Halted      = 1'b0;

        // While reset is held the outputs stay idle, even though the state already reads CLR
        if (Reset) begin
            unique case (state)
                S_CLR: begin
                    ARF_FunSel = FUN_CLR;
                    ARF_RegSel = ARF_PC;
                    RF_FunSel  = FUN_CLR;
                    RF_RegSel  = 4'b0000;
                    nextState  = S_RUN;
                    nextStep   = T0;
                end
                S_RUN: begin
                    nextStep = T0;
                    case (stepCnt)
                        T0, T1: begin
                            ARF_OutDSel = 2'b00;
                            Mem_CS      = 1'b0;
                            IR_Write    = 1'b1;
                            IR_LH       = (stepCnt == T1);
                            ARF_FunSel  = FUN_INC;
                            ARF_RegSel  = ARF_PC;
                            nextStep    = stepCnt + SC_WIDTH'(1);
                        end
                        T2: begin
                            case (opc)
                                OPC_BRA, OPC_BNE, OPC_BEQ: begin
                                    if (opc == OPC_BRA || (opc == OPC_BNE && !zFlag) ||
                                        (opc == OPC_BEQ && zFlag)) begin
                                        MuxBSel    = 2'b11;
                                        ARF_FunSel = FUN_LOAD;
                                        ARF_RegSel = ARF_PC;
                                    end
                                end
                                OPC_LDI: begin
                                    MuxASel   = 2'b11;
                                    RF_FunSel = FUN_LOAD;
                                    RF_RegSel = rdEn;
                                end
                                OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR: begin
                                    RF_OutASel = {1'b0, rs1};
                                    RF_OutBSel = {1'b0, rs2};
                                    ALU_WF     = 1'b1;
                                    MuxASel    = 2'b00;
                                    RF_FunSel  = FUN_LOAD;
                                    RF_RegSel  = rdEn;
                                    case (opc)
                                        OPC_ADD: ALU_FunSel = 5'b10100;
                                        OPC_SUB: ALU_FunSel = 5'b10110;
                                        OPC_AND: ALU_FunSel = 5'b10111;
                                        default: ALU_FunSel = 5'b11000;
                                    endcase
                                end
                                OPC_LD, OPC_ST: begin
                                    MuxBSel    = 2'b11;
                                    ARF_FunSel = FUN_LOAD;
                                    ARF_RegSel = ARF_AR;
                                    nextStep   = T3;
                                end
                                HALT_OPC: nextState = S_HALT;
                                default: ;
                            endcase
                        end
                        T3: begin
                            ARF_OutDSel = 2'b10;
                            Mem_CS      = 1'b0;
                            if (opc == OPC_LD) begin
                                MuxASel   = 2'b10;
                                RF_FunSel = FUN_LOAD;
                                RF_RegSel = rdEn;
                            end else begin
                                RF_OutASel = {1'b0, rd};
                                ALU_FunSel = 5'b10000;
                                MuxCSel    = 1'b0;
                                Mem_WR     = 1'b1;
                            end
                        end
                        default: nextStep = T0;
                    endcase
                end
                S_HALT: Halted = 1'b1;
                default: nextState = S_CLR;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks fetch/decode for each instruction class
// and compares control outputs against hand-derived values.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  Flags;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel;
    logic [2:0]  ARF_FunSel, ARF_RegSel;
    logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel, Halted;

    int checks = 0;
    int errors = 0;

    control_sequencer #(.SC_WIDTH(3), .HALT_OPC(6'h3F)) dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .Flags(Flags),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel),
        .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
        .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
        .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
        .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
        .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .Halted(Halted)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // From a T0 sample point: advance to T1, present the instruction, advance to T2
    task automatic fetch(input logic [15:0] ir);
        tick();
        IROut = ir;
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0; IROut = 16'h0000; Flags = 4'b0000;
        #12;
        checks++; if (Mem_CS !== 1'b1) begin errors++; $display("FAIL rst_mem_cs: got %b expected 1", Mem_CS); end
        checks++; if (RF_RegSel !== 4'b1111) begin errors++; $display("FAIL rst_rf_regsel: got %b expected 1111", RF_RegSel); end
        checks++; if (ARF_RegSel !== 3'b111) begin errors++; $display("FAIL rst_arf_regsel: got %b expected 111", ARF_RegSel); end
        checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", Halted); end
        Reset = 1'b1;
        #1;
        checks++; if (ARF_FunSel !== 3'b011 || ARF_RegSel !== 3'b011) begin errors++; $display("FAIL clr_arf: got fun %b reg %b expected 011 011", ARF_FunSel, ARF_RegSel); end
        checks++; if (RF_FunSel !== 3'b011 || RF_RegSel !== 4'b0000) begin errors++; $display("FAIL clr_rf: got fun %b reg %b expected 011 0000", RF_FunSel, RF_RegSel); end
        tick();
        checks++; if (Mem_CS !== 1'b0 || IR_LH !== 1'b0 || IR_Write !== 1'b1) begin errors++; $display("FAIL t0_fetch: got cs %b lh %b wr %b expected 0 0 1", Mem_CS, IR_LH, IR_Write); end
        checks++; if (ARF_FunSel !== 3'b001 || ARF_RegSel !== 3'b011) begin errors++; $display("FAIL t0_pc_inc: got fun %b reg %b expected 001 011", ARF_FunSel, ARF_RegSel); end
        tick();
        checks++; if (IR_LH !== 1'b1 || Mem_CS !== 1'b0 || IR_Write !== 1'b1) begin errors++; $display("FAIL t1_fetch: got lh %b cs %b wr %b expected 1 0 1", IR_LH, Mem_CS, IR_Write); end
    endtask

    task automatic test_ld_abort();
        // LD R2,0x80 fetched, then reset dropped in the middle of T3
        IROut = 16'h2180;
        tick();
        checks++; if (MuxBSel !== 2'b11 || ARF_FunSel !== 3'b010 || ARF_RegSel !== 3'b101) begin errors++; $display("FAIL ld_t2: got muxb %b fun %b reg %b expected 11 010 101", MuxBSel, ARF_FunSel, ARF_RegSel); end
        tick();
        checks++; if (Mem_CS !== 1'b0 || ARF_OutDSel !== 2'b10 || MuxASel !== 2'b10 || RF_RegSel !== 4'b1011 || RF_FunSel !== 3'b010) begin errors++; $display("FAIL ld_t3: got cs %b outd %b muxa %b rreg %b rfun %b expected 0 10 10 1011 010", Mem_CS, ARF_OutDSel, MuxASel, RF_RegSel, RF_FunSel); end
        #2 Reset = 1'b0;
        #1;
        checks++; if (Mem_CS !== 1'b1 || RF_RegSel !== 4'b1111 || MuxASel !== 2'b00) begin errors++; $display("FAIL ld_abort: got cs %b rreg %b muxa %b expected 1 1111 00", Mem_CS, RF_RegSel, MuxASel); end
        @(posedge Clock);
        #3 Reset = 1'b1;
        #1;
        checks++; if (ARF_FunSel !== 3'b011 || RF_RegSel !== 4'b0000 || Mem_CS !== 1'b1) begin errors++; $display("FAIL abort_clr: got afun %b rreg %b cs %b expected 011 0000 1", ARF_FunSel, RF_RegSel, Mem_CS); end
        tick();
        checks++; if (Mem_CS !== 1'b0 || IR_LH !== 1'b0 || ARF_RegSel !== 3'b011) begin errors++; $display("FAIL abort_t0: got cs %b lh %b areg %b expected 0 0 011", Mem_CS, IR_LH, ARF_RegSel); end
    endtask

    task automatic test_ldi();
        fetch(16'h0C55);
        checks++; if (MuxASel !== 2'b11 || RF_FunSel !== 3'b010 || RF_RegSel !== 4'b0111) begin errors++; $display("FAIL ldi_t2: got muxa %b fun %b reg %b expected 11 010 0111", MuxASel, RF_FunSel, RF_RegSel); end
        tick();
        checks++; if (Mem_CS !== 1'b0 || IR_LH !== 1'b0 || ARF_FunSel !== 3'b001) begin errors++; $display("FAIL ldi_back_t0: got cs %b lh %b afun %b expected 0 0 001", Mem_CS, IR_LH, ARF_FunSel); end
    endtask

    task automatic test_alu();
        fetch(16'h1218);
        checks++; if (RF_OutASel !== 3'b001 || RF_OutBSel !== 3'b010) begin errors++; $display("FAIL add_outsel: got a %b b %b expected 001 010", RF_OutASel, RF_OutBSel); end
        checks++; if (ALU_FunSel !== 5'b10100 || ALU_WF !== 1'b1 || RF_RegSel !== 4'b1101 || MuxASel !== 2'b00) begin errors++; $display("FAIL add_t2: got fun %b wf %b reg %b muxa %b expected 10100 1 1101 00", ALU_FunSel, ALU_WF, RF_RegSel, MuxASel); end
        tick();
        // ORR R4, R1, R4: opc 07, Rd=11, Rs1=00, Rs2=11
        fetch(16'h1F0C);
        checks++; if (ALU_FunSel !== 5'b11000 || RF_RegSel !== 4'b1110 || RF_OutASel !== 3'b000 || RF_OutBSel !== 3'b011) begin errors++; $display("FAIL orr_t2: got fun %b reg %b a %b b %b expected 11000 1110 000 011", ALU_FunSel, RF_RegSel, RF_OutASel, RF_OutBSel); end
        tick();
    endtask

    task automatic test_branch();
        Flags = 4'b1000;
        fetch(16'h0440);
        checks++; if (ARF_RegSel !== 3'b111 || RF_RegSel !== 4'b1111) begin errors++; $display("FAIL bne_not_taken: got areg %b rreg %b expected 111 1111", ARF_RegSel, RF_RegSel); end
        tick();
        Flags = 4'b0000;
        fetch(16'h0440);
        checks++; if (MuxBSel !== 2'b11 || ARF_FunSel !== 3'b010 || ARF_RegSel !== 3'b011) begin errors++; $display("FAIL bne_taken: got muxb %b fun %b reg %b expected 11 010 011", MuxBSel, ARF_FunSel, ARF_RegSel); end
        tick();
        fetch(16'h0840);
        checks++; if (ARF_RegSel !== 3'b111) begin errors++; $display("FAIL beq_not_taken: got areg %b expected 111", ARF_RegSel); end
        tick();
        checks++; if (IR_Write !== 1'b1 || IR_LH !== 1'b0) begin errors++; $display("FAIL beq_back_t0: got wr %b lh %b expected 1 0", IR_Write, IR_LH); end
    endtask

    task automatic test_st();
        fetch(16'h2480);
        checks++; if (ARF_RegSel !== 3'b101 || ARF_FunSel !== 3'b010 || Mem_CS !== 1'b1) begin errors++; $display("FAIL st_t2: got areg %b afun %b cs %b expected 101 010 1", ARF_RegSel, ARF_FunSel, Mem_CS); end
        tick();
        checks++; if (Mem_WR !== 1'b1 || Mem_CS !== 1'b0 || ARF_OutDSel !== 2'b10 || MuxCSel !== 1'b0) begin errors++; $display("FAIL st_t3_mem: got wr %b cs %b outd %b muxc %b expected 1 0 10 0", Mem_WR, Mem_CS, ARF_OutDSel, MuxCSel); end
        checks++; if (ALU_FunSel !== 5'b10000 || RF_OutASel !== 3'b000 || RF_RegSel !== 4'b1111) begin errors++; $display("FAIL st_t3_alu: got fun %b a %b rreg %b expected 10000 000 1111", ALU_FunSel, RF_OutASel, RF_RegSel); end
        tick();
        checks++; if (Mem_WR !== 1'b0 || Mem_CS !== 1'b0 || IR_LH !== 1'b0 || ARF_RegSel !== 3'b011) begin errors++; $display("FAIL st_back_t0: got wr %b cs %b lh %b areg %b expected 0 0 0 011", Mem_WR, Mem_CS, IR_LH, ARF_RegSel); end
    endtask

    task automatic test_nop();
        fetch(16'h2800);
        checks++; if (Mem_CS !== 1'b1 || ARF_RegSel !== 3'b111 || RF_RegSel !== 4'b1111 || ALU_WF !== 1'b0 || IR_Write !== 1'b0) begin errors++; $display("FAIL nop_t2: got cs %b areg %b rreg %b wf %b irw %b expected 1 111 1111 0 0", Mem_CS, ARF_RegSel, RF_RegSel, ALU_WF, IR_Write); end
        tick();
        checks++; if (Mem_CS !== 1'b0 || IR_LH !== 1'b0) begin errors++; $display("FAIL nop_back_t0: got cs %b lh %b expected 0 0", Mem_CS, IR_LH); end
    endtask

    task automatic test_halt();
        fetch(16'hFC00);
        checks++; if (Halted !== 1'b0 || ARF_RegSel !== 3'b111) begin errors++; $display("FAIL halt_t2: got halted %b areg %b expected 0 111", Halted, ARF_RegSel); end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (Halted !== 1'b1 || Mem_CS !== 1'b1 || IR_Write !== 1'b0) begin errors++; $display("FAIL halt_hold[%0d]: got halted %b cs %b irw %b expected 1 1 0", i, Halted, Mem_CS, IR_Write); end
        end
        #2 Reset = 1'b0;
        #1;
        checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL halt_reset: got halted %b expected 0", Halted); end
        @(posedge Clock);
        #3 Reset = 1'b1;
        #1;
        checks++; if (ARF_FunSel !== 3'b011 || RF_RegSel !== 4'b0000 || Halted !== 1'b0) begin errors++; $display("FAIL halt_clr: got afun %b rreg %b halted %b expected 011 0000 0", ARF_FunSel, RF_RegSel, Halted); end
        tick();
        checks++; if (Mem_CS !== 1'b0 || IR_LH !== 1'b0 || ARF_RegSel !== 3'b011) begin errors++; $display("FAIL halt_t0: got cs %b lh %b areg %b expected 0 0 011", Mem_CS, IR_LH, ARF_RegSel); end
    endtask

    initial begin
        test_reset();
        test_ld_abort();
        test_ldi();
        test_alu();
        test_branch();
        test_st();
        test_nop();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
